// File: rtl/fifo_axis_pkg.sv
// Shared types and defaults for the ap_fifo to AXI4-Stream reader.
// Imported by the interface, skid buffer and top.
package fifo_axis_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/fifo_axis_reader_if.sv
// FIFO read-side and AXI4-Stream signals of the reader.
// master = reader side, slave = FIFO/stream environment.
interface fifo_axis_reader_if
  import fifo_axis_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty_n;
  logic             fifo_read;
  logic [WIDTH-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;

  modport master (
    input  fifo_dout,
    input  fifo_empty_n,
    input  m_axis_tready,
    output fifo_read,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport slave (
    output fifo_dout,
    output fifo_empty_n,
    output m_axis_tready,
    input  fifo_read,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is the output head.
// Carries data plus a last-beat tag in the top bit.
module axis_skid_buf #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] ent0_q, ent0_d;
  logic [DW-1:0] ent1_q, ent1_d;
  logic [1:0]    occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = din_i;
        else               ent1_d = din_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // head leaves while a new word arrives
        if (occ_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains frame_len words from an FWFT ap_fifo into AXI4-Stream.
// FSM and counters here; buffering in axis_skid_buf.
module fifo_axis_reader
  import fifo_axis_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  fifo_axis_reader_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] req_q, req_d;
  logic [CNT_W-1:0] out_q, out_d;

  logic             push;
  logic             pop;
  logic             last_tag;
  logic [WIDTH:0]   head;
  logic [1:0]       occ;

  assign last_tag = (req_q == len_q - CNT_W'(1));

  // issue depends only on registered state and empty_n
  assign push = (state_q == S_RUN) && !ap_rst &&
                bus.fifo_empty_n && (req_q != len_q) &&
                (occ != 2'd2);

  assign pop = bus.m_axis_tvalid && bus.m_axis_tready;

  axis_skid_buf #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push_i(push),
    .din_i ({last_tag, bus.fifo_dout}),
    .pop_i (pop),
    .dout_o(head),
    .occ_o (occ)
  );

  assign bus.fifo_read     = push;
  assign bus.m_axis_tvalid = (occ != 2'd0);
  assign bus.m_axis_tdata  = head[WIDTH-1:0];
  assign bus.m_axis_tlast  = head[WIDTH];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req_d   = req_q;
    out_d   = out_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = frame_len;
          req_d   = '0;
          out_d   = '0;
          state_d = (frame_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) req_d = req_q + CNT_W'(1);
        if (pop)  out_d = out_q + CNT_W'(1);
        if (pop && bus.m_axis_tlast) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      req_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      req_q   <= req_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Random-stimulus bench for fifo_axis_reader with a queue-based
// FIFO model and expected-beat scoreboard.
module tb_fifo_axis_reader;

  localparam int W = 32;
  localparam int C = 16;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         start = 1'b0;
  logic [C-1:0] frame_len = '0;
  logic         busy;
  logic         done;

  fifo_axis_reader_if #(.WIDTH(W)) bus ();

  fifo_axis_reader #(
    .WIDTH(W),
    .CNT_W(C)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .start    (start),
    .frame_len(frame_len),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mst_t;

  logic [W-1:0] fifo_q[$];
  beat_t        exp_q[$];
  mst_t         mst = M_IDLE;

  int checks = 0;
  int errors = 0;
  int len_m = 0;
  int pops_frame = 0;
  int beats_seen = 0;
  int rdy_mode = 0;
  int stall_after = 0;
  int stall_left = 0;
  bit stall_now = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic         prev_l = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty_n = (fifo_q.size() > 0) && !stall_now;
    bus.fifo_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    drive_fifo();
  endtask

  // one clock: sample at negedge, advance model at posedge+1
  task automatic cycle();
    bit    pop;
    bit    beat;
    beat_t e;
    e.d = '0;
    e.l = 1'b0;
    @(negedge ap_clk);
    check("busy", busy, mst != M_IDLE);
    check("done", done, mst == M_DONE);
    if (mst != M_RUN) check("rd_outside_run", bus.fifo_read, 0);
    if (ap_rst) check("rd_in_reset", bus.fifo_read, 0);
    if (prev_stall) begin
      check("stall_tvalid", bus.m_axis_tvalid, 1);
      check("stall_tdata", bus.m_axis_tdata, prev_d);
      check("stall_tlast", bus.m_axis_tlast, prev_l);
    end
    pop  = bus.fifo_read && bus.fifo_empty_n;
    beat = bus.m_axis_tvalid && bus.m_axis_tready;
    if (pop && !ap_rst) begin
      check("over_read", pops_frame < len_m, 1);
      pops_frame++;
    end
    if (beat && !ap_rst) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", bus.m_axis_tdata, e.d);
        check("tlast", bus.m_axis_tlast, e.l);
      end
    end
    prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready && !ap_rst;
    prev_d     = bus.m_axis_tdata;
    prev_l     = bus.m_axis_tlast;
    if (ap_rst) begin
      mst = M_IDLE;
      exp_q.delete();
      len_m = 0;
      pops_frame = 0;
    end else begin
      case (mst)
        M_IDLE: if (start) begin
          len_m = int'(frame_len);
          pops_frame = 0;
          beats_seen = 0;
          exp_q.delete();
          for (int i = 0; i < len_m; i++) begin
            beat_t b;
            b.d = fifo_q[i];
            b.l = (i == len_m - 1);
            exp_q.push_back(b);
          end
          mst = (len_m == 0) ? M_DONE : M_RUN;
        end
        M_RUN: if (beat && e.l) begin
          check("pop_count", pops_frame, len_m);
          mst = M_DONE;
        end
        default: mst = M_IDLE;
      endcase
    end
    @(posedge ap_clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    start  = 1'b0;
    ap_rst = 1'b0;
    case (rdy_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = ~bus.m_axis_tready;
      default: bus.m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    stall_now = (stall_left > 0) && (pops_frame >= stall_after) &&
                (mst == M_RUN);
    if (stall_now) stall_left--;
    drive_fifo();
  endtask

  task automatic run_frame(input int len, output int ncyc);
    frame_len = C'(len);
    start = 1'b1;
    cycle();
    ncyc = 1;
    while (mst != M_IDLE && ncyc < 300) begin
      if (rdy_mode == 2 && mst == M_RUN && exp_q.size() > 1 &&
          $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        frame_len = C'($urandom_range(1, 20));
      end
      cycle();
      ncyc++;
    end
    check("frame_timeout", mst == M_IDLE, 1);
    check("all_beats", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    bus.m_axis_tready = 1'b1;
    bus.fifo_empty_n  = 1'b0;
    bus.fifo_dout     = '0;
    @(posedge ap_clk);
    #1;
    cycle();
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_tlast", bus.m_axis_tlast, 0);
    check("rst_tdata", bus.m_axis_tdata, 0);
    check("rst_read", bus.fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + i);
    drive_fifo();
    rdy_mode = 0;
    run_frame(4, n);
    check("t1_cycles", n, 7);
    check("t1_left", fifo_q.size(), 0);

    preload(8);
    rdy_mode = 1;
    run_frame(8, n);
    check("t2_left", fifo_q.size(), 0);

    preload(6);
    rdy_mode = 0;
    stall_after = 3;
    stall_left = 5;
    run_frame(6, n);
    check("t3_cycles", n, 14);
    check("t3_stall_used", stall_left, 0);

    preload(2);
    frame_len = '0;
    start = 1'b1;
    cycle();
    frame_len = C'(5);
    start = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("t4_left", fifo_q.size(), 2);

    preload(8);
    run_frame(3, n);
    check("t5a_left", fifo_q.size(), 7);
    rdy_mode = 2;
    run_frame(7, n);
    check("t5b_left", fifo_q.size(), 0);

    rdy_mode = 0;
    preload(8);
    frame_len = C'(6);
    start = 1'b1;
    cycle();
    k = 0;
    while (beats_seen < 2 && k < 50) begin
      cycle();
      k++;
    end
    check("t6_two_beats", beats_seen, 2);
    ap_rst = 1'b1;
    cycle();
    check("t6_tvalid", bus.m_axis_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    run_frame(2, n);
    check("t6_cycles", n, 5);
    check("t6_left", fifo_q.size(), 3);

    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(0, 12);
      if (fifo_q.size() < len) preload(len - fifo_q.size());
      preload($urandom_range(0, 3));
      rdy_mode = $urandom_range(0, 2);
      stall_after = $urandom_range(0, len);
      stall_left = $urandom_range(0, 4);
      run_frame(len, n);
    end
    stall_left = 0;
    for (int i = 0; i < 3; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
